hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter ALU_LAT, default 1, meaning countdown loaded for an ALU-class producer (RTYPE/ADDI/SLTI).
REQ-003 SHALL have parameter LOAD_LAT, default 2, meaning countdown loaded for a LOAD-class producer (LW).
REQ-004 SHALL have parameter BYPASS_SLACK, default 1, meaning largest countdown a non-branch consumer tolerates through forwarding.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: id_valid  in  1  instruction present in ID; id_rs, id_rt  in  clog2(NREGS) each  source registers; id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-007 SHALL have ports: id_is_branch  in  1  BEQ/BNE, operands compared in ID; id_wr_en  in  1  writes a register; id_wr_reg  in  clog2(NREGS)  destination; id_wr_class  in  1  0=ALU, 1=LOAD.
REQ-008 SHALL have ports: flush  in  1  squash the ID instruction; stall  out  1  hold PC/IF/ID, insert bubble.
REQ-009 SHALL have ports: stall_cause  out  2  00 none, 01 ALU-to-branch, 10 load-use, 11 load-to-branch; pending  out  NREGS  bit r set when count[r]!=0; stall_cycles  out  32  stall statistic.

Function
REQ-010 SHALL keep one countdown count[r] per register r, wide enough for max(ALU_LAT, LOAD_LAT).
REQ-011 SHALL decrement every nonzero count[r] by 1 per clock, saturating at 0.
REQ-012 SHALL issue when id_valid && !stall && !flush, loading count[id_wr_reg] with ALU_LAT or LOAD_LAT per id_wr_class if id_wr_en and id_wr_reg!=0.
REQ-013 SHALL give load priority over decrement on the same register in the same cycle (newer writer wins, WAW overwrite).
REQ-014 SHALL compute stall combinationally: any used source s!=0 with count[s] > need, need=0 if id_is_branch else BYPASS_SLACK; gated by id_valid.
REQ-015 SHALL force stall=0 and issue nothing when flush=1.
REQ-016 SHALL set stall_cause from the producer class of the worst-case offending source (LOAD over ALU); 00 when stall=0.
REQ-017 SHALL never stall on register 0 or on a source whose use bit is 0.
REQ-018 SHALL, with defaults, yield: ALU->branch 1 bubble, LW->ALU/SW/ADDI 1 bubble, LW->branch 2 bubbles, ALU->ALU 0 bubbles.

Reset
REQ-019 SHALL on reset clear all count[r] (pending=0), stall_cycles=0; stall=0 and stall_cause=00 while reset is asserted.
REQ-020 SHALL discard all in-flight hazards when reset asserts mid-stall; first post-reset instruction issues without stall.

Configuration
REQ-021 SHALL, with STALL_STATS_EN defined, increment stall_cycles each clock with stall=1, saturating at 32'hFFFF_FFFF.
REQ-022 SHALL, without STALL_STATS_EN, drive stall_cycles constant 0 and infer no counter.

Structure
REQ-023 SHALL take opcode constants (LW, SW, RTYPE, BEQ, BNE, J, ADDI, SLTI), the producer-class and stall_cause encodings, and default latencies from shared package cpu_hazard_pkg.
REQ-024 SHALL instantiate sub-module hazard_reg_counter (load/decrement/saturate, class bit) once per register via generate.

Verification
REQ-025 SHALL cover: issue LW to r21, next cycle ID=ADD reading r21 -> stall=1, cause=10 for 1 cycle, then stall=0.
REQ-026 SHALL cover: issue LW to r21, next cycle ID=BEQ on r21 -> stall=1 for 2 cycles, cause=11, then issue.
REQ-027 SHALL cover: issue ADD to r21, next cycle ID=BNE on rt=r21 -> stall=1 for 1 cycle, cause=01; ID=ADD instead -> no stall.
REQ-028 SHALL cover: ADD to r0 then BEQ r0,r0 -> no stall; LW r21 then ADD r21 with use_rs=0 -> no stall.
REQ-029 SHALL cover: LW r21 then ALU r21 issued over it, then BEQ r21 -> 1 bubble (cause=01); flush during stall -> stall=0, no issue.
REQ-030 SHALL cover: reset asserted mid load-use stall -> pending=0, stall=0 immediately; STALL_STATS_EN build counts exactly 3 cycles for REQ-025+026 sequence.

Source files
------------

// File: rtl/cpu_hazard_pkg.sv
// Shared CPU hazard definitions: opcodes, producer classes, stall causes and
// the default producer latencies used by the ID-stage hazard scoreboard.
package cpu_hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    CLS_ALU  = 1'b0,
    CLS_LOAD = 1'b1
  } wr_class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ALU_BR   = 2'b01,
    CAUSE_LOAD_USE = 2'b10,
    CAUSE_LOAD_BR  = 2'b11
  } stall_cause_e;

  localparam int DEF_ALU_LAT      = 1;
  localparam int DEF_LOAD_LAT     = 2;
  localparam int DEF_BYPASS_SLACK = 1;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard scoreboard: the decoded instruction and flush
// flow from the pipeline (master) into the scoreboard (slave), stall flows back.
interface hazard_scoreboard_if #(parameter int NREGS = 32);

  localparam int RW = $clog2(NREGS);

  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_is_branch;
  logic          id_wr_en;
  logic [RW-1:0] id_wr_reg;
  logic          id_wr_class;
  logic          flush;
  logic          stall;
  logic [1:0]    stall_cause;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_wr_en, id_wr_reg, id_wr_class, flush,
    input  stall, stall_cause
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
           id_wr_en, id_wr_reg, id_wr_class, flush,
    output stall, stall_cause
  );

endinterface

// File: rtl/hazard_reg_counter.sv
// Per-register result countdown: a new writer reloads it (winning over the
// decrement), otherwise it counts down to zero. Also remembers producer class.
module hazard_reg_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          load_class,
  output logic [CW-1:0] count,
  output logic          cls
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      cls   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      cls   <= load_class;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard with countdown per architectural register.
// Define STALL_STATS_EN to build the saturating stall_cycles counter.
module hazard_scoreboard
  import cpu_hazard_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int ALU_LAT      = DEF_ALU_LAT,
  parameter int LOAD_LAT     = DEF_LOAD_LAT,
  parameter int BYPASS_SLACK = DEF_BYPASS_SLACK
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   id,
  output logic [NREGS-1:0]     pending,
  output logic [31:0]          stall_cycles
);

  localparam int RW     = $clog2(NREGS);
  localparam int MAXLAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [CW-1:0] cnt [NREGS];
  logic          cls [NREGS];
  logic          issue;
  logic [CW-1:0] load_val;

  assign issue    = id.id_valid && !id.stall && !id.flush && !reset;
  assign load_val = id.id_wr_class ? CW'(LOAD_LAT) : CW'(ALU_LAT);

  // Register 0 never loads, so its counter stays at zero forever.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    hazard_reg_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (issue && id.id_wr_en && (id.id_wr_reg == RW'(r)) && (r != 0)),
      .load_val   (load_val),
      .load_class (id.id_wr_class),
      .count      (cnt[r]),
      .cls        (cls[r])
    );
    assign pending[r] = (cnt[r] != '0);
  end

  logic [31:0]  need;
  logic         rs_hit;
  logic         rt_hit;
  logic         load_hit;
  stall_cause_e cause;

  // A source is an offender if its producer is further away than the
  // consumer can absorb; branches compare in ID and so absorb nothing.
  always_comb begin
    need     = id.id_is_branch ? 32'd0 : 32'(BYPASS_SLACK);
    rs_hit   = id.id_use_rs && (id.id_rs != '0) && (32'(cnt[id.id_rs]) > need);
    rt_hit   = id.id_use_rt && (id.id_rt != '0) && (32'(cnt[id.id_rt]) > need);
    load_hit = (rs_hit && cls[id.id_rs]) || (rt_hit && cls[id.id_rt]);
    id.stall = id.id_valid && !id.flush && !reset && (rs_hit || rt_hit);
    cause    = CAUSE_NONE;
    if (id.stall) begin
      if (load_hit)
        cause = id.id_is_branch ? CAUSE_LOAD_BR : CAUSE_LOAD_USE;
      else
        cause = CAUSE_ALU_BR;
    end
    id.stall_cause = cause;
  end

`ifdef STALL_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stat_q <= '0;
    else if (id.stall && (stat_q != 32'hFFFF_FFFF))
      stat_q <= stat_q + 32'd1;
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a remaining-latency model checked
// every negedge, plus hand-computed expectations for each hazard scenario.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int ALU_LAT = 1;
  localparam int LOAD_LAT = 2;
  localparam int SLACK = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pending;
  logic [31:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  hazard_scoreboard_if #(.NREGS(NREGS)) hif();

  hazard_scoreboard #(
    .NREGS(NREGS), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .BYPASS_SLACK(SLACK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id           (hif),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Model: cycles until each register's result is forwardable, plus class.
  int          mleft [NREGS];
  bit          mload [NREGS];
  logic [31:0] mstat = '0;

  function automatic logic [2:0] model_out();
    int need;
    bit rs_hit, rt_hit, ld;
    if (reset || !hif.id_valid || hif.flush) return 3'b000;
    need   = hif.id_is_branch ? 0 : SLACK;
    rs_hit = hif.id_use_rs && hif.id_rs != 0 && mleft[hif.id_rs] > need;
    rt_hit = hif.id_use_rt && hif.id_rt != 0 && mleft[hif.id_rt] > need;
    if (!(rs_hit || rt_hit)) return 3'b000;
    ld = (rs_hit && mload[hif.id_rs]) || (rt_hit && mload[hif.id_rt]);
    if (ld) return hif.id_is_branch ? 3'b111 : 3'b110;
    return 3'b101;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int r = 0; r < NREGS; r++) p[r] = (mleft[r] != 0);
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [2:0] e;
    bit iss;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mleft[r] = 0;
        mload[r] = 1'b0;
      end
      mstat = '0;
    end else begin
      e   = model_out();
      iss = hif.id_valid && !hif.flush && !e[2];
`ifdef STALL_STATS_EN
      if (e[2] && mstat != 32'hFFFF_FFFF) mstat = mstat + 1;
`endif
      for (int r = 0; r < NREGS; r++) if (mleft[r] > 0) mleft[r]--;
      if (iss && hif.id_wr_en && hif.id_wr_reg != 0) begin
        mleft[hif.id_wr_reg] = hif.id_wr_class ? LOAD_LAT : ALU_LAT;
        mload[hif.id_wr_reg] = hif.id_wr_class;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    e = model_out();
    checks += 4;
    if (hif.stall !== e[2]) begin
      fails++;
      $display("[TB] FAIL model_stall t=%0t got=%b want=%b", $time, hif.stall, e[2]);
    end
    if (hif.stall_cause !== e[1:0]) begin
      fails++;
      $display("[TB] FAIL model_cause t=%0t got=%b want=%b", $time, hif.stall_cause, e[1:0]);
    end
    if (pending !== model_pending()) begin
      fails++;
      $display("[TB] FAIL model_pending t=%0t got=%h want=%h", $time, pending, model_pending());
    end
    if (stall_cycles !== mstat) begin
      fails++;
      $display("[TB] FAIL model_stats t=%0t got=%0d want=%0d", $time, stall_cycles, mstat);
    end
  end

  task automatic applyStimulus(input bit v, input int rs, input int rt, input bit urs,
                               input bit urt, input bit br, input bit we, input int wr,
                               input bit cl, input bit fl);
    hif.id_valid     = v;
    hif.id_rs        = 5'(rs);
    hif.id_rt        = 5'(rt);
    hif.id_use_rs    = urs;
    hif.id_use_rt    = urt;
    hif.id_is_branch = br;
    hif.id_wr_en     = we;
    hif.id_wr_reg    = 5'(wr);
    hif.id_wr_class  = cl;
    hif.flush        = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_stall, input logic [1:0] exp_cause);
    #1;
    checks += 2;
    if (hif.stall !== exp_stall) begin
      fails++;
      $display("[TB] FAIL %s stall got=%b want=%b", name, hif.stall, exp_stall);
    end
    if (hif.stall_cause !== exp_cause) begin
      fails++;
      $display("[TB] FAIL %s cause got=%b want=%b", name, hif.stall_cause, exp_cause);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    idle();
    #2;
    checkOutput("reset_state", 1'b0, 2'b00);
    checkValue("reset_pending", pending, 32'h0);
    checkValue("reset_stats", stall_cycles, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // LW r21 then ADD r22 <- r21: one load-use bubble
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    checkOutput("lw_issue", 1'b0, 2'b00);
    tick();
    applyStimulus(1, 21, 3, 1, 1, 0, 1, 22, 0, 0);
    checkOutput("loaduse_stall", 1'b1, 2'b10);
    tick();
    checkOutput("loaduse_release", 1'b0, 2'b00);
    tick();
    idle(); tick(3);

    // LW r21 then BEQ r21,r4: two bubbles
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    tick();
    applyStimulus(1, 21, 4, 1, 1, 1, 0, 0, 0, 0);
    checkOutput("loadbr_stall1", 1'b1, 2'b11);
    tick();
    checkOutput("loadbr_stall2", 1'b1, 2'b11);
    tick();
    checkOutput("loadbr_release", 1'b0, 2'b00);
    tick();
    idle(); tick(3);
`ifdef STALL_STATS_EN
    checkValue("stats_three", stall_cycles, 32'd3);
`else
    checkValue("stats_off", stall_cycles, 32'd0);
`endif

    // ADD r21 then BNE r5,r21: one bubble; ADD consumer: none
    applyStimulus(1, 1, 2, 1, 1, 0, 1, 21, 0, 0);
    tick();
    applyStimulus(1, 5, 21, 1, 1, 1, 0, 0, 0, 0);
    checkOutput("alubr_stall", 1'b1, 2'b01);
    tick();
    checkOutput("alubr_release", 1'b0, 2'b00);
    tick();
    applyStimulus(1, 1, 2, 1, 1, 0, 1, 21, 0, 0);
    tick();
    applyStimulus(1, 21, 21, 1, 1, 0, 1, 23, 0, 0);
    checkOutput("aluadd_nostall", 1'b0, 2'b00);
    tick();
    idle(); tick(3);

    // Writes to r0 never create hazards; unused sources never stall
    applyStimulus(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    checkOutput("r0_nostall", 1'b0, 2'b00);
    checkValue("r0_pending", pending, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    tick();
    applyStimulus(1, 21, 2, 0, 1, 0, 1, 22, 0, 0);
    checkOutput("unused_nostall", 1'b0, 2'b00);
    tick();
    idle(); tick(3);

    // LW r21 overwritten by ALU r21, then BEQ r21: one ALU bubble
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 0, 0);
    checkOutput("waw_issue", 1'b0, 2'b00);
    tick();
    applyStimulus(1, 21, 0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("waw_br_stall", 1'b1, 2'b01);
    tick();
    checkOutput("waw_br_release", 1'b0, 2'b00);
    tick();
    idle(); tick(3);

    // Flush over a would-be stall: no stall, flushed writer never issues
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    tick();
    applyStimulus(1, 21, 0, 1, 0, 0, 1, 5, 0, 1);
    checkOutput("flush_nostall", 1'b0, 2'b00);
    tick();
    idle();
    checkValue("flush_pending", pending, 32'h0020_0000);
    tick(3);

    // Reset mid load-use stall clears everything at once
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 21, 1, 0);
    tick();
    applyStimulus(1, 21, 3, 1, 1, 0, 1, 22, 0, 0);
    checkOutput("pre_reset_stall", 1'b1, 2'b10);
    reset = 1'b1;
    checkOutput("reset_midstall", 1'b0, 2'b00);
    checkValue("reset_mid_pending", pending, 32'h0);
    tick();
    reset = 1'b0;
    checkOutput("post_reset_issue", 1'b0, 2'b00);
    tick();
    idle(); tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
